skinny_uart_frame: RTL and testbench

Byte-level framing stage between the UART byte receiver/transmitter and the SKINNY-128-384 core. It assembles a 64-byte request frame into the core's plaintext, key, tweak1 and tweak2 buses, then pulses start to the core. When the core reports done, it captures the 128-bit ciphertext and streams it back as 16 bytes with a valid/ready handshake.

---
 rtl/skinny_uart_pkg.sv | 17 +
 rtl/skinny_uart_tx_unload.sv | 58 +++++
 rtl/skinny_uart_frame.sv | 126 ++++++++++++
 tb/tb_skinny_uart_frame.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/skinny_uart_pkg.sv
// Shared constants for the SKINNY-128-384 UART framing stage.
package skinny_uart_pkg;

    localparam int FRAME_BYTES  = 64;
    localparam int CIPHER_BYTES = 16;

    localparam int RX_CNT_W = $clog2(FRAME_BYTES);
    localparam int TX_CNT_W = $clog2(CIPHER_BYTES);

    // Frame FSM encoding, kept as plain constants so older tools accept it
    typedef logic [1:0] state_t;
    localparam state_t ST_LOAD  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_SEND  = 2'd3;

endpackage

// File: rtl/skinny_uart_tx_unload.sv
// Ciphertext unload: 128-bit shift register streamed MSB-first as 16 bytes
// over a valid/ready handshake.
module skinny_uart_tx_unload
    import skinny_uart_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [127:0] cipher_i,
    input  logic         tx_ready_i,
    output logic [7:0]   tx_data_o,
    output logic         tx_valid_o,
    output logic         last_o
);

    logic [127:0]         shift_q, shift_d;
    logic [TX_CNT_W-1:0]  cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 last;

    // Load, shift on acceptance, and drop valid after the final byte
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last    = 1'b0;
        if (load_i) begin
            shift_d = cipher_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready_i) begin
            shift_d = {shift_q[119:0], 8'h00};
            cnt_d   = cnt_q + TX_CNT_W'(1);
            if (cnt_q == TX_CNT_W'(CIPHER_BYTES - 1)) begin
                valid_d = 1'b0;
                last    = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data_o  = shift_q[127:120];
    assign tx_valid_o = valid_q;
    assign last_o     = last;

endmodule

// File: rtl/skinny_uart_frame.sv
// Framing stage: collects a 64-byte request into the SKINNY operand buses,
// starts the core, then returns the 16-byte ciphertext to the transmitter.
module skinny_uart_frame
    import skinny_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [7:0]   rx_data_i,
    input  logic         rx_valid_i,
    output logic [7:0]   tx_data_o,
    output logic         tx_valid_o,
    input  logic         tx_ready_i,
    output logic [127:0] input_o,
    output logic [127:0] key_o,
    output logic [127:0] tweak1_o,
    output logic [127:0] tweak2_o,
    output logic         start_o,
    input  logic         done_i,
    input  logic [127:0] cipher_i,
    output logic         busy_o,
    output logic         overrun_o
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Expiry is detected one count early so the counter clears exactly
    // TIMEOUT idle cycles after the last byte.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [511:0]         frame_q, frame_d;
    logic [RX_CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 overrun_q, overrun_d;
    logic                 start_q, busy_q;
    logic                 tx_load;
    logic                 tx_last;

    // Frame assembly, idle timeout and sequencing of the core handshake
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        rx_cnt_d  = rx_cnt_q;
        timer_d   = timer_q;
        overrun_d = overrun_q;
        tx_load   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (rx_valid_i) begin
                    frame_d  = {frame_q[503:0], rx_data_i};
                    rx_cnt_d = rx_cnt_q + RX_CNT_W'(1);
                    timer_d  = '0;
                    if (rx_cnt_q == RX_CNT_W'(FRAME_BYTES - 1)) begin
                        state_d = ST_START;
                    end
                end else if (TIMEOUT != 0 && rx_cnt_q != '0) begin
                    // Stale bytes stay in the frame; a full new frame overwrites them
                    if (timer_q == TMR_LAST) begin
                        rx_cnt_d = '0;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (done_i) begin
                    tx_load = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_last) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        if (rx_valid_i && state_q != ST_LOAD) begin
            overrun_d = 1'b1;
        end
    end

    // State registers; start and busy are registered from the next state
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_LOAD;
            frame_q   <= '0;
            rx_cnt_q  <= '0;
            timer_q   <= '0;
            overrun_q <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            rx_cnt_q  <= rx_cnt_d;
            timer_q   <= timer_d;
            overrun_q <= overrun_d;
            start_q   <= (state_d == ST_START);
            busy_q    <= (state_d != ST_LOAD);
        end
    end

    skinny_uart_tx_unload u_tx_unload (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tx_load),
        .cipher_i   (cipher_i),
        .tx_ready_i (tx_ready_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .last_o     (tx_last)
    );

    assign input_o   = frame_q[511:384];
    assign key_o     = frame_q[383:256];
    assign tweak1_o  = frame_q[255:128];
    assign tweak2_o  = frame_q[127:0];
    assign start_o   = start_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_skinny_uart_frame.sv
// Directed bench for skinny_uart_frame with a simple core stub.
module tb_skinny_uart_frame;

    localparam logic [127:0] EXP_INPUT  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] EXP_KEY    = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] EXP_TWEAK1 = 128'h202122232425262728292A2B2C2D2E2F;
    localparam logic [127:0] EXP_TWEAK2 = 128'h303132333435363738393A3B3C3D3E3F;
    localparam logic [127:0] CIPHER     = 128'h00112233445566778899AABBCCDDEEFF;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [7:0]   rx_data_i;
    logic         rx_valid_i;
    logic [7:0]   tx_data_o;
    logic         tx_valid_o;
    logic         tx_ready_i;
    logic [127:0] input_o, key_o, tweak1_o, tweak2_o;
    logic         start_o;
    logic         done_i = 1'b1;
    logic [127:0] cipher_i;
    logic         busy_o;
    logic         overrun_o;

    int tests_run = 0;
    int tests_failed = 0;
    int stub_cnt = 0;

    always #5 clk = ~clk;

    skinny_uart_frame #(.TIMEOUT(100)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .input_o    (input_o),
        .key_o      (key_o),
        .tweak1_o   (tweak1_o),
        .tweak2_o   (tweak2_o),
        .start_o    (start_o),
        .done_i     (done_i),
        .cipher_i   (cipher_i),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o)
    );

    // Core stub: done drops after start and returns 40 cycles later
    always @(posedge clk) begin
        if (start_o) begin
            done_i   <= 1'b0;
            stub_cnt <= 40;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) done_i <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        step();
        rx_valid_i = 1'b0;
    endtask

    // Sends bytes 0x00..0x3F and checks operands and the start pulse
    task automatic send_frame();
        int early = 0;
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i));
            if (i < 63 && start_o) early++;
        end
        $display("[TB] frame sent, start_o=%0b", start_o);
        check_eq("early_start", 128'(early), 128'd0);
        check_eq("start_high", 128'(start_o), 128'd1);
        check_eq("input_o", input_o, EXP_INPUT);
        check_eq("key_o", key_o, EXP_KEY);
        check_eq("tweak1_o", tweak1_o, EXP_TWEAK1);
        check_eq("tweak2_o", tweak2_o, EXP_TWEAK2);
        step();
        check_eq("start_low", 128'(start_o), 128'd0);
        check_eq("busy_run", 128'(busy_o), 128'd1);
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        while (!tx_valid_o && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check_eq("tx_valid_timeout", 128'(tx_valid_o), 128'd1);
    endtask

    // Receives 16 bytes; bp cycles of ready-low precede each acceptance
    task automatic recv(input int bp);
        logic [7:0] e;
        for (int k = 0; k < 16; k++) begin
            e = 8'(k * 17);
            tx_ready_i = 1'b0;
            for (int c = 0; c < bp; c++) begin
                check_eq("bp_valid", 128'(tx_valid_o), 128'd1);
                check_eq("bp_data", 128'(tx_data_o), 128'(e));
                step();
            end
            tx_ready_i = 1'b1;
            check_eq("tx_valid", 128'(tx_valid_o), 128'd1);
            check_eq("tx_data", 128'(tx_data_o), 128'(e));
            $display("[TB] tx byte %0d = %02h", k, tx_data_o);
            step();
            tx_ready_i = 1'b0;
        end
        check_eq("tx_valid_end", 128'(tx_valid_o), 128'd0);
        check_eq("busy_end", 128'(busy_o), 128'd0);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cipher_i   = CIPHER;
        rst_i      = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b0;
        repeat (3) step();

        // Reset values
        check_eq("rst_tx_data", 128'(tx_data_o), 128'd0);
        check_eq("rst_tx_valid", 128'(tx_valid_o), 128'd0);
        check_eq("rst_start", 128'(start_o), 128'd0);
        check_eq("rst_busy", 128'(busy_o), 128'd0);
        check_eq("rst_overrun", 128'(overrun_o), 128'd0);
        check_eq("rst_operands", input_o | key_o | tweak1_o | tweak2_o, 128'd0);
        rst_i = 1'b1;
        step();

        // Basic frame, unthrottled unload
        $display("[TB] scenario: basic");
        send_frame();
        wait_tx(n);
        check_eq("capture_latency", 128'(n), 128'd41);
        recv(0);

        // Backpressure
        $display("[TB] scenario: backpressure");
        send_frame();
        wait_tx(n);
        recv(5);
        check_eq("no_overrun", 128'(overrun_o), 128'd0);

        // Idle timeout discards a partial frame
        $display("[TB] scenario: timeout");
        for (int i = 0; i < 10; i++) send_byte(8'hEE);
        repeat (100) step();
        send_frame();
        wait_tx(n);
        recv(0);

        // Overrun during RUN
        $display("[TB] scenario: overrun");
        send_frame();
        repeat (3) step();
        send_byte(8'h55);
        check_eq("overrun_set", 128'(overrun_o), 128'd1);
        check_eq("ovr_input_o", input_o, EXP_INPUT);
        check_eq("ovr_tweak2_o", tweak2_o, EXP_TWEAK2);
        wait_tx(n);
        recv(0);
        check_eq("overrun_sticky", 128'(overrun_o), 128'd1);
        send_frame();
        wait_tx(n);
        recv(0);

        // Reset in the middle of SEND
        $display("[TB] scenario: reset mid-send");
        send_frame();
        wait_tx(n);
        tx_ready_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            check_eq("pre_rst_data", 128'(tx_data_o), 128'(8'(k * 17)));
            step();
        end
        tx_ready_i = 1'b0;
        rst_i = 1'b0;
        step();
        check_eq("mid_rst_tx_valid", 128'(tx_valid_o), 128'd0);
        check_eq("mid_rst_busy", 128'(busy_o), 128'd0);
        check_eq("mid_rst_overrun", 128'(overrun_o), 128'd0);
        check_eq("mid_rst_start", 128'(start_o), 128'd0);
        rst_i = 1'b1;
        send_frame();
        wait_tx(n);
        recv(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
